// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states and the link-wide mode and width constants.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    // Mode 0 is shared with the master side of the link
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam int   SPI_DEFAULT_W = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with registered rise/fall pulses
// derived from the last stage and a delayed copy of it.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    logic              rise_q;
    logic              fall_q;

    // Synchronizer chain, delayed copy and edge pulse registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~dly_q;
            fall_q <= ~sync_q[STAGES-1] & dly_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// Mode 0, MSB-first SPI responder oversampled by clk; single-entry tx holding register,
// rx words reported with a one-cycle valid pulse.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DEFAULT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sclk_i,
    input  logic              csb_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic sclk_rise_s, sclk_fall_s, csb_rise_s, csb_fall_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              oe_q, oe_d;
    logic              word_seen_q, word_seen_d;
    logic              load_s;
    logic [DATA_W-1:0] rx_word_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .resetb(resetb), .d_i(sclk_i), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb_sync (
        .clk(clk), .resetb(resetb), .d_i(csb_i), .rise_o(csb_rise_s), .fall_o(csb_fall_s)
    );

    // Plain synchronizer for mosi; data is stable well before the sclk rise is acted on
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign rx_word_s = {rx_shift_q[DATA_W-2:0], mosi_s};

    // Next-state logic: csb rise has priority over any sclk edge in the same cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        oe_d         = oe_q;
        word_seen_d  = word_seen_q;
        load_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (csb_fall_s) begin
                    state_d     = SHIFT;
                    load_s      = 1'b1;
                    cnt_d       = CNT_ZERO;
                    oe_d        = 1'b1;
                    word_seen_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (csb_rise_s) begin
                    state_d    = IDLE;
                    cnt_d      = CNT_ZERO;
                    oe_d       = 1'b0;
                    tx_shift_d = {DATA_W{1'b0}};
                    rx_shift_d = {DATA_W{1'b0}};
                end else if (sclk_rise_s) begin
                    rx_shift_d = rx_word_s;
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d   = rx_word_s;
                        rx_valid_d  = 1'b1;
                        cnt_d       = CNT_ZERO;
                        word_seen_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (sclk_fall_s) begin
                    if (cnt_q != CNT_ZERO) begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end else if (word_seen_q) begin
                        load_s = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load samples the holding register as it was before this cycle's accept
        if (load_s) begin
            tx_shift_d   = hold_valid_q ? hold_q : {DATA_W{1'b0}};
            underrun_d   = ~hold_valid_q;
            hold_valid_d = 1'b0;
        end else begin
            underrun_d = 1'b0;
        end

        if (tx_valid_i && !hold_valid_q) begin
            hold_d       = tx_data_i;
            hold_valid_d = 1'b1;
        end else begin
            hold_d = hold_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            tx_shift_q   <= {DATA_W{1'b0}};
            rx_shift_q   <= {DATA_W{1'b0}};
            rx_data_q    <= {DATA_W{1'b0}};
            hold_q       <= {DATA_W{1'b0}};
            hold_valid_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            oe_q         <= 1'b0;
            word_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            oe_q         <= oe_d;
            word_seen_q  <= word_seen_d;
        end
    end

    assign miso_o        = tx_shift_q[DATA_W-1];
    assign miso_oe_o     = oe_q;
    assign tx_ready_o    = ~hold_valid_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = underrun_q;
    assign busy_o        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed and random bench for spi_slave: the bench plays the SPI master and scoreboards
// rx words, latency, underruns and idle/busy levels against its own expectations.
module tb_spi_slave;

    localparam int W    = 16;
    localparam int SYNC = 2;

    logic clk, resetb, sclk, csb, mosi;
    logic miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
    logic [W-1:0] tx_data, rx_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int underrun_cnt = 0;
    int rx_pulse_cnt = 0;
    int csb_stable = 0;
    logic prev_csb = 1'b1;
    logic [W-1:0] model_rx = 16'h0000;
    logic [W-1:0] exp_rx_q[$];

    spi_slave #(.DATA_W(W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetb(resetb), .sclk_i(sclk), .csb_i(csb), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .tx_underrun_o(tx_underrun), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Compare process: rx scoreboard, latency and steady-state pin levels every cycle
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                model_rx   = 16'h0000;
                csb_stable = 0;
            end else begin
                if (rx_valid) begin
                    rx_pulse_cnt++;
                    if (exp_rx_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got %h expected no word", rx_data);
                    end else begin
                        e = exp_rx_q.pop_front();
                        check("rx_word", 32'(rx_data), 32'(e));
                        check("rx_latency", 32'(cyc - last_rise_cyc), 32'(SYNC + 2));
                        model_rx = e;
                    end
                end else begin
                    check("rx_hold", 32'(rx_data), 32'(model_rx));
                end
                if (tx_underrun) underrun_cnt++;
                if (csb == prev_csb) csb_stable++;
                else csb_stable = 0;
                if (csb_stable >= 8) begin
                    check("busy", 32'(busy), 32'(!csb));
                    check("miso_oe", 32'(miso_oe), 32'(!csb));
                    if (csb) check("miso_idle", 32'(miso), 32'h0);
                end
            end
            prev_csb = csb;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic half(input bit jit);
        wait_clk(4 + (jit ? int'($urandom_range(1, 0)) : 0));
    endtask

    task automatic push_tx(input logic [W-1:0] d);
        for (int i = 0; i < 20 && !tx_ready; i++) wait_clk(1);
        check("tx_ready_wait", 32'(tx_ready), 32'h1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("tx_ready_fall", 32'(tx_ready), 32'h0);
    endtask

    task automatic csb_low();
        csb = 1'b0;
        half(1'b0);
    endtask

    // Shift nbits of one word; sample miso just before each rise, no trailing fall when last
    task automatic shift_word(input logic [W-1:0] mw, input logic [W-1:0] em,
                              input int nbits, input bit last, input bit jit);
        logic [W-1:0] got;
        got = 16'h0000;
        if (nbits == W) exp_rx_q.push_back(mw);
        for (int i = W - 1; i >= W - nbits; i--) begin
            mosi = mw[i];
            half(jit);
            got[i] = miso;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            half(jit);
            if (!(last && i == W - nbits)) sclk = 1'b0;
        end
        if (nbits == W) check("miso_word", 32'(got), 32'(em));
    endtask

    task automatic end_frame();
        csb = 1'b1;
        half(1'b0);
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(10);
    endtask

    task automatic frame1(input logic [W-1:0] mw, input logic [W-1:0] em);
        csb_low();
        shift_word(mw, em, W, 1'b1, 1'b0);
        end_frame();
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_miso_oe", 32'(miso_oe), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_underrun", 32'(tx_underrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    task automatic single_word_case();
        int r0, u0;
        r0 = rx_pulse_cnt;
        u0 = underrun_cnt;
        push_tx(16'hA5C3);
        frame1(16'h1234, 16'hA5C3);
        check("single_rx_data", 32'(rx_data), 32'h1234);
        check("single_rx_pulses", 32'(rx_pulse_cnt - r0), 32'h1);
        check("single_underruns", 32'(underrun_cnt - u0), 32'h0);
        check("single_busy_after", 32'(busy), 32'h0);
    endtask

    initial begin
        int r0, u0;
        logic [W-1:0] tw, mw;
        resetb = 1'b0; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
        tx_data = 16'h0000; tx_valid = 1'b0;
        wait_clk(3);
        check_reset_outputs();
        resetb = 1'b1;
        wait_clk(4);

        single_word_case();

        // Two words in one frame, second word supplied after the first load
        r0 = rx_pulse_cnt;
        u0 = underrun_cnt;
        push_tx(16'h00FF);
        csb_low();
        push_tx(16'hFF00);
        shift_word(16'hBEEF, 16'h00FF, W, 1'b0, 1'b0);
        shift_word(16'hCAFE, 16'hFF00, W, 1'b1, 1'b0);
        end_frame();
        check("two_rx_pulses", 32'(rx_pulse_cnt - r0), 32'h2);
        check("two_underruns", 32'(underrun_cnt - u0), 32'h0);
        check("two_rx_data", 32'(rx_data), 32'hCAFE);

        // Underrun with an empty holding register
        u0 = underrun_cnt;
        frame1(16'h5555, 16'h0000);
        check("underrun_pulses", 32'(underrun_cnt - u0), 32'h1);
        check("underrun_rx_data", 32'(rx_data), 32'h5555);

        // Abort after 7 bits, then a full frame
        r0 = rx_pulse_cnt;
        csb_low();
        shift_word(16'hFFFF, 16'h0000, 7, 1'b1, 1'b0);
        end_frame();
        check("abort_rx_pulses", 32'(rx_pulse_cnt - r0), 32'h0);
        check("abort_rx_data", 32'(rx_data), 32'h5555);
        frame1(16'h0001, 16'h0000);
        check("after_abort_rx_data", 32'(rx_data), 32'h0001);

        // Reset after 9 bits with a pending word in the holding register
        push_tx(16'h1357);
        csb_low();
        push_tx(16'h2468);
        shift_word(16'h9999, 16'h0000, 9, 1'b1, 1'b0);
        resetb = 1'b0;
        csb = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #1;
        check_reset_outputs();
        wait_clk(2);
        resetb = 1'b1;
        wait_clk(6);
        single_word_case();

        // Random words with sclk half-period jitter
        for (int k = 0; k < 100; k++) begin
            tw = W'($urandom);
            mw = W'($urandom);
            push_tx(tw);
            csb_low();
            shift_word(mw, tw, W, 1'b1, 1'b1);
            end_frame();
        end
        check("rand_last_rx", 32'(rx_data), 32'(mw));
        check("rx_queue_empty", 32'(exp_rx_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) that sits on the far end of the team's SPI master link.
- Lets the FPGA-side peripheral or test harness answer the CPU's SPI transactions.
- Mode 0 (CPOL=0, CPHA=0), MSB first, DATA_W-bit words.
- Asynchronous SPI pins are oversampled by the system clock clk; parallel rx/tx data is exchanged through valid/ready-style handshakes.

Parameters:
- DATA_W, 16, SPI word width in bits. Equals the CPU word. Legal range 2..32.
- SYNC_STAGES, 2, synchronizer flops on sclk_i, csb_i and mosi_i. Minimum 2.

Ports:
- clk  input  1  system clock. Frequency must be at least 8x the SCLK frequency.
- resetb  input  1  reset, asynchronous, active-low.
- sclk_i  input  1  SPI clock from the master. Asynchronous to clk.
- csb_i  input  1  chip select, active-low. Asynchronous to clk.
- mosi_i  input  1  serial data from the master.
- miso_o  output  1  serial data to the master.
- miso_oe_o  output  1  MISO output enable; pad tristates when 0.
- tx_data_i  input  DATA_W  next word to send.
- tx_valid_i  input  1  tx_data_i is valid.
- tx_ready_o  output  1  tx holding register is empty.
- rx_data_o  output  DATA_W  last complete received word.
- rx_valid_o  output  1  one-cycle pulse: rx_data_o updated.
- tx_underrun_o  output  1  one-cycle pulse: a word started with an empty tx holding register.
- busy_o  output  1  frame in progress (synchronized csb low).

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0, bit counter=0, FSM=IDLE, synchronizers=idle levels (sclk=0, csb=1, mosi=0).
- Synchronization and edge detection:
  - sclk, csb and mosi each pass through SYNC_STAGES flops.
  - A rise/fall is detected by comparing the last stage with a delayed copy.
  - All internal actions occur in the clk cycle after edge detection.
- TX holding register: single entry.
  - Accepted when tx_valid_i & tx_ready_o.
  - tx_ready_o falls the next cycle and rises the cycle after the word is loaded into the shift register.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on a csb fall. In that cycle: load the tx shift register from the holding register, drive the MSB on miso_o, set miso_oe_o=1, clear the bit counter, set busy_o=1.
  - SHIFT, sclk rise: shift the synchronized mosi into the LSB of the rx shift register; increment the bit counter.
  - SHIFT, bit counter reaches DATA_W on a rise: copy the rx shift register to rx_data_o, pulse rx_valid_o for 1 cycle, wrap the counter to 0. Stay in SHIFT, because continuous multi-word frames are legal.
  - SHIFT, sclk fall with counter != 0: shift the tx register left; drive the new MSB.
  - SHIFT, sclk fall with counter == 0 (word boundary, after at least one word): reload the tx register from the holding register; drive its MSB.
  - SHIFT -> IDLE on a csb rise, from any bit position:
    - partial word discarded, no rx_valid_o;
    - counter cleared, miso_oe_o=0, miso_o=0, busy_o=0;
    - the holding register keeps any unconsumed word.
- Underrun: any load with an empty holding register shifts out all zeros and pulses tx_underrun_o.
- Simultaneous events:
  - A tx accept in the same cycle as a load is not seen by that load. The load underruns, and the new word waits for the next load.
  - A csb rise and an sclk rise in the same cycle: csb wins, so the bit is discarded.
- rx_data_o holds its value until the next complete word; there is no back-pressure on rx.
- Latency: rx_valid_o asserts SYNC_STAGES+2 clk cycles after the DATA_W-th SCLK rising edge at the pin.
- Reset mid-frame: all state returns to reset values immediately. The holding register is emptied.

Decomposition:
- Package spi_pkg:
  - typedef for the FSM state enum {IDLE, SHIFT};
  - constant for SPI mode 0 (CPOL/CPHA) and default width 16, shared with the master side.
- One natural sub-module: spi_sync_edge.
  - N-stage synchronizer plus rise/fall pulse outputs.
  - Instantiated for sclk_i and csb_i; plain synchronizer for mosi_i.

Test Plan:
- Single word: preload tx 16'hA5C3; master sends 16'h1234 at clk/8 -> miso bits read 16'hA5C3; rx_data_o=16'h1234; exactly one rx_valid_o pulse; busy_o low after the csb rise.
- Two words in one frame: preload 16'h00FF, supply 16'hFF00 after the first tx_ready_o, master sends 16'hBEEF then 16'hCAFE -> rx_valid_o pulses with 16'hBEEF, then 16'hCAFE; miso returns 16'h00FF, then 16'hFF00; no tx_underrun_o.
- Underrun: empty holding register, master sends 16'h5555 -> miso all zeros; one tx_underrun_o pulse at the csb fall; rx_data_o=16'h5555.
- Abort: csb rises after 7 bits of 16'hFFFF -> no rx_valid_o; rx_data_o unchanged; next full frame with 16'h0001 -> rx_data_o=16'h0001.
- Reset mid-frame: assert resetb low after 9 bits -> all outputs at reset values; tx_ready_o=1; the next frame behaves as the single-word case.
- Sampling: SCLK at clk/8 with mosi changing only on SCLK falls and 1 clk of random jitter -> all 100 random words received correctly.
